// File: rtl/alu_reservation_station.sv
// -----------------------------------------------------------------------------
// alu_reservation_station
//
// Reservation station in front of the combinational ALU. It buffers dispatched
// ALU, branch and jump ops and watches the ALU and memory result buses so that
// operands waiting on older ROB ids can pick up their values. Each cycle it
// issues at most one op whose operands are both present.
//
// Ports
//   clk_in, rst_in           clock, asynchronous active-low reset
//   rdy_in                   global ready; when low every register holds
//   flush_pipline            mispredict flush (synchronous, beats everything)
//   dispatch_*               op coming from the dispatcher; dispatch_ready is
//                            high while at least one entry is free
//   alu_rdy/res_ins_id/alu_res   ALU result bus (operand wakeup)
//   mem_rdy/mem_ins_id/mem_res   memory result bus (operand wakeup)
//   have_ins ... is_compressed_ins   registered ALU issue port
// -----------------------------------------------------------------------------
module alu_reservation_station #(
    parameter int CSU_SIZE_BITS = 4,
    parameter int RS_SIZE_BITS  = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_pipline,

    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  logic [CSU_SIZE_BITS-1:0] dispatch_ins_id,
    input  logic [6:0]               dispatch_opcode,
    input  logic [2:0]               dispatch_funct3,
    input  logic [6:0]               dispatch_funct7,
    input  logic [31:0]              dispatch_imm,
    input  logic [5:0]               dispatch_shamt,
    input  logic [31:0]              dispatch_PC,
    input  logic                     dispatch_is_c,
    input  logic                     dispatch_rs1_wait,
    input  logic [CSU_SIZE_BITS-1:0] dispatch_rs1_dep,
    input  logic [31:0]              dispatch_rs1_val,
    input  logic                     dispatch_rs2_wait,
    input  logic [CSU_SIZE_BITS-1:0] dispatch_rs2_dep,
    input  logic [31:0]              dispatch_rs2_val,

    input  logic                     alu_rdy,
    input  logic [CSU_SIZE_BITS-1:0] res_ins_id,
    input  logic [31:0]              alu_res,
    input  logic                     mem_rdy,
    input  logic [CSU_SIZE_BITS-1:0] mem_ins_id,
    input  logic [31:0]              mem_res,

    output logic                     have_ins,
    output logic [CSU_SIZE_BITS-1:0] ins_id,
    output logic [31:0]              rs1_val,
    output logic [31:0]              rs2_val,
    output logic [31:0]              imm_val,
    output logic [5:0]               shamt_val,
    output logic [6:0]               opcode,
    output logic [2:0]               funct3,
    output logic [6:0]               funct7,
    output logic [31:0]              request_PC,
    output logic                     is_compressed_ins
);

    localparam int ENTRIES = 1 << RS_SIZE_BITS;

    // Entry storage (packed so whole arrays can be cleared at once).
    logic [ENTRIES-1:0]                          valid_r;
    logic [ENTRIES-1:0][CSU_SIZE_BITS-1:0]       ent_id_r;
    logic [ENTRIES-1:0][6:0]                     ent_opcode_r;
    logic [ENTRIES-1:0][2:0]                     ent_funct3_r;
    logic [ENTRIES-1:0][6:0]                     ent_funct7_r;
    logic [ENTRIES-1:0][31:0]                    ent_imm_r;
    logic [ENTRIES-1:0][5:0]                     ent_shamt_r;
    logic [ENTRIES-1:0][31:0]                    ent_pc_r;
    logic [ENTRIES-1:0]                          ent_is_c_r;
    logic [ENTRIES-1:0]                          rs1_wait_r;
    logic [ENTRIES-1:0][CSU_SIZE_BITS-1:0]       rs1_dep_r;
    logic [ENTRIES-1:0][31:0]                    rs1_val_r;
    logic [ENTRIES-1:0]                          rs2_wait_r;
    logic [ENTRIES-1:0][CSU_SIZE_BITS-1:0]       rs2_dep_r;
    logic [ENTRIES-1:0][31:0]                    rs2_val_r;

    logic [ENTRIES-1:0]      ready_s;
    logic                    issue_any_s;
    logic [RS_SIZE_BITS-1:0] issue_idx_s;
    logic [RS_SIZE_BITS-1:0] disp_slot_s;
    logic                    disp_accept_s;
    logic [32:0]             disp_rs1_s;
    logic [32:0]             disp_rs2_s;

    // Operand snoop: returns {still_waiting, value}. The ALU bus is checked
    // first so it wins if both buses ever carry the same id.
    function automatic logic [32:0] capture(
        input logic                     op_wait,
        input logic [CSU_SIZE_BITS-1:0] dep,
        input logic [31:0]              val,
        input logic                     a_rdy,
        input logic [CSU_SIZE_BITS-1:0] a_id,
        input logic [31:0]              a_res,
        input logic                     m_rdy,
        input logic [CSU_SIZE_BITS-1:0] m_id,
        input logic [31:0]              m_res
    );
        logic [32:0] r;
        if (op_wait && a_rdy && (dep == a_id)) begin
            r = {1'b0, a_res};
        end else if (op_wait && m_rdy && (dep == m_id)) begin
            r = {1'b0, m_res};
        end else begin
            r = {op_wait, val};
        end
        return r;
    endfunction

    // Readiness and acceptance, all from registered entry state so that a
    // same-cycle wakeup or issue never feeds back combinationally.
    always_comb begin
        ready_s        = valid_r & ~rs1_wait_r & ~rs2_wait_r;
        issue_any_s    = |ready_s;
        dispatch_ready = ~&valid_r;
        disp_accept_s  = dispatch_valid & dispatch_ready;
    end

    // Lowest-index priority encoders for the issue pick and the free slot;
    // scanning downward lets the lowest hit overwrite higher ones.
    always_comb begin
        issue_idx_s = {RS_SIZE_BITS{1'b0}};
        disp_slot_s = {RS_SIZE_BITS{1'b0}};
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            issue_idx_s = ready_s[i]  ? RS_SIZE_BITS'(i) : issue_idx_s;
            disp_slot_s = !valid_r[i] ? RS_SIZE_BITS'(i) : disp_slot_s;
        end
    end

    // Same-cycle bypass of result buses into the op being dispatched.
    always_comb begin
        disp_rs1_s = capture(dispatch_rs1_wait, dispatch_rs1_dep, dispatch_rs1_val,
                             alu_rdy, res_ins_id, alu_res, mem_rdy, mem_ins_id, mem_res);
        disp_rs2_s = capture(dispatch_rs2_wait, dispatch_rs2_dep, dispatch_rs2_val,
                             alu_rdy, res_ins_id, alu_res, mem_rdy, mem_ins_id, mem_res);
    end

    // Entry array: flush clears, otherwise wakeup, issue-invalidate and dispatch.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_r      <= '0;
            ent_id_r     <= '0;
            ent_opcode_r <= '0;
            ent_funct3_r <= '0;
            ent_funct7_r <= '0;
            ent_imm_r    <= '0;
            ent_shamt_r  <= '0;
            ent_pc_r     <= '0;
            ent_is_c_r   <= '0;
            rs1_wait_r   <= '0;
            rs1_dep_r    <= '0;
            rs1_val_r    <= '0;
            rs2_wait_r   <= '0;
            rs2_dep_r    <= '0;
            rs2_val_r    <= '0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                valid_r <= '0;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    {rs1_wait_r[i], rs1_val_r[i]} <= capture(rs1_wait_r[i], rs1_dep_r[i], rs1_val_r[i],
                        alu_rdy, res_ins_id, alu_res, mem_rdy, mem_ins_id, mem_res);
                    {rs2_wait_r[i], rs2_val_r[i]} <= capture(rs2_wait_r[i], rs2_dep_r[i], rs2_val_r[i],
                        alu_rdy, res_ins_id, alu_res, mem_rdy, mem_ins_id, mem_res);
                end
                if (issue_any_s) begin
                    valid_r[issue_idx_s] <= 1'b0;
                end
                // The free slot is never the issuing slot, so both updates coexist.
                if (disp_accept_s) begin
                    valid_r[disp_slot_s]      <= 1'b1;
                    ent_id_r[disp_slot_s]     <= dispatch_ins_id;
                    ent_opcode_r[disp_slot_s] <= dispatch_opcode;
                    ent_funct3_r[disp_slot_s] <= dispatch_funct3;
                    ent_funct7_r[disp_slot_s] <= dispatch_funct7;
                    ent_imm_r[disp_slot_s]    <= dispatch_imm;
                    ent_shamt_r[disp_slot_s]  <= dispatch_shamt;
                    ent_pc_r[disp_slot_s]     <= dispatch_PC;
                    ent_is_c_r[disp_slot_s]   <= dispatch_is_c;
                    rs1_dep_r[disp_slot_s]    <= dispatch_rs1_dep;
                    rs2_dep_r[disp_slot_s]    <= dispatch_rs2_dep;
                    {rs1_wait_r[disp_slot_s], rs1_val_r[disp_slot_s]} <= disp_rs1_s;
                    {rs2_wait_r[disp_slot_s], rs2_val_r[disp_slot_s]} <= disp_rs2_s;
                end
            end
        end
    end

    // Issue port registers: have_ins is a one-cycle pulse per issued op.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            have_ins          <= 1'b0;
            ins_id            <= '0;
            rs1_val           <= 32'd0;
            rs2_val           <= 32'd0;
            imm_val           <= 32'd0;
            shamt_val         <= 6'd0;
            opcode            <= 7'd0;
            funct3            <= 3'd0;
            funct7            <= 7'd0;
            request_PC        <= 32'd0;
            is_compressed_ins <= 1'b0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                have_ins <= 1'b0;
            end else if (issue_any_s) begin
                have_ins          <= 1'b1;
                ins_id            <= ent_id_r[issue_idx_s];
                rs1_val           <= rs1_val_r[issue_idx_s];
                rs2_val           <= rs2_val_r[issue_idx_s];
                imm_val           <= ent_imm_r[issue_idx_s];
                shamt_val         <= ent_shamt_r[issue_idx_s];
                opcode            <= ent_opcode_r[issue_idx_s];
                funct3            <= ent_funct3_r[issue_idx_s];
                funct7            <= ent_funct7_r[issue_idx_s];
                request_PC        <= ent_pc_r[issue_idx_s];
                is_compressed_ins <= ent_is_c_r[issue_idx_s];
            end else begin
                have_ins <= 1'b0;
            end
        end
    end

endmodule
